// File: rtl/majority_pkg.sv
// Shared definitions for the majority-vote pipeline: count-width helper and vote mode encoding.
package majority_pkg;

    typedef enum logic {
        MODE_MAJ = 1'b0,
        MODE_THR = 1'b1
    } mode_e;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int countWidth(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/majority_pipe_popcount.sv
// Combinational population count of an N-bit word into a countWidth(N)-bit result.
module popcount
    import majority_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]                i_bits,
    output logic [countWidth(N)-1:0]    o_count
);

    localparam int CW = countWidth(N);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/majority_pipe.sv
// Two-stage majority/threshold voter with valid/ready handshake on both sides.
module majority_pipe
    import majority_pkg::*;
#(
    parameter int N       = 32,
    parameter bit TIE_VAL = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_seq,
    input  logic                        in_mode,
    input  logic [countWidth(N)-1:0]    in_thresh,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_maj,
    output logic [countWidth(N)-1:0]    out_ones,
    output logic                        out_tie
);

    localparam int CW = countWidth(N);
    localparam logic [CW:0] N_EXT = (CW + 1)'(N);

    logic [CW-1:0] w_count;
    logic          w_r1;
    logic          w_r2;
    logic [CW:0]   w_twice;
    logic          w_maj;
    logic          w_tie;

    logic          r_v1;
    logic [CW-1:0] r_ones1;
    mode_e         r_mode1;
    logic [CW-1:0] r_thresh1;

    logic          r_v2;
    logic          r_maj2;
    logic [CW-1:0] r_ones2;
    logic          r_tie2;

    popcount #(.N(N)) u_popcount (
        .i_bits  (in_seq),
        .o_count (w_count)
    );

    assign w_r2     = !r_v2 || out_ready;
    assign w_r1     = !r_v1 || w_r2;
    assign in_ready = w_r1;

    // Comparing 2*ones against N avoids a subtraction; equality can only occur for even N.
    assign w_twice = {r_ones1, 1'b0};
    assign w_tie   = (w_twice == N_EXT);

    always_comb begin
        w_maj = 1'b0;
        if (r_mode1 == MODE_THR) begin
            w_maj = (r_ones1 >= r_thresh1);
        end else if (w_twice > N_EXT) begin
            w_maj = 1'b1;
        end else if (w_twice == N_EXT) begin
            w_maj = TIE_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_ones1   <= '0;
            r_mode1   <= MODE_MAJ;
            r_thresh1 <= '0;
        end else if (w_r1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_ones1   <= w_count;
                r_mode1   <= mode_e'(in_mode);
                r_thresh1 <= in_thresh;
            end
        end
    end

    // S2 only loads while it can hand off, so a stalled result stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_maj2  <= 1'b0;
            r_ones2 <= '0;
            r_tie2  <= 1'b0;
        end else if (w_r2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_maj2  <= w_maj;
                r_ones2 <= r_ones1;
                r_tie2  <= w_tie;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_maj   = r_maj2;
    assign out_ones  = r_ones2;
    assign out_tie   = r_tie2;

endmodule

// File: tb/tb_majority_pipe.sv
// Directed-table, backpressure, reset and random checks of majority_pipe at N=8 (both tie values) and N=32.
module tb_majority_pipe;

    typedef struct {
        logic [31:0] seq;
        logic        mode;
        logic [5:0]  thresh;
        logic [3:0]  ones8;
        logic        maj8Lo;
        logic        maj8Hi;
        logic        tie8;
        logic [5:0]  ones32;
        logic        maj32;
        logic        tie32;
    } vecT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic [31:0] inSeq = '0;
    logic        inMode = 1'b0;
    logic [5:0]  inThresh = '0;
    logic        outReady = 1'b1;

    logic       readyA, validA, majA, tieA;
    logic [3:0] onesA;
    logic       readyB, validB, majB, tieB;
    logic [3:0] onesB;
    logic       readyC, validC, majC, tieC;
    logic [5:0] onesC;

    int   total = 0;
    int   bad = 0;
    vecT  vecs[12];
    vecT  expQ[$];

    always #5 clk = ~clk;

    majority_pipe #(.N(8), .TIE_VAL(1'b0)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(readyA),
        .in_seq(inSeq[7:0]), .in_mode(inMode), .in_thresh(inThresh[3:0]),
        .out_valid(validA), .out_ready(outReady), .out_maj(majA),
        .out_ones(onesA), .out_tie(tieA)
    );

    majority_pipe #(.N(8), .TIE_VAL(1'b1)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(readyB),
        .in_seq(inSeq[7:0]), .in_mode(inMode), .in_thresh(inThresh[3:0]),
        .out_valid(validB), .out_ready(outReady), .out_maj(majB),
        .out_ones(onesB), .out_tie(tieB)
    );

    majority_pipe #(.N(32), .TIE_VAL(1'b1)) dutC (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(readyC),
        .in_seq(inSeq), .in_mode(inMode), .in_thresh(inThresh),
        .out_valid(validC), .out_ready(outReady), .out_maj(majC),
        .out_ones(onesC), .out_tie(tieC)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkRes(input string tag, input vecT e);
        checkOutput({tag, ".validA"}, 32'(validA), 32'd1);
        checkOutput({tag, ".onesA"}, 32'(onesA), 32'(e.ones8));
        checkOutput({tag, ".majA"}, 32'(majA), 32'(e.maj8Lo));
        checkOutput({tag, ".tieA"}, 32'(tieA), 32'(e.tie8));
        checkOutput({tag, ".onesB"}, 32'(onesB), 32'(e.ones8));
        checkOutput({tag, ".majB"}, 32'(majB), 32'(e.maj8Hi));
        checkOutput({tag, ".tieB"}, 32'(tieB), 32'(e.tie8));
        checkOutput({tag, ".validC"}, 32'(validC), 32'd1);
        checkOutput({tag, ".onesC"}, 32'(onesC), 32'(e.ones32));
        checkOutput({tag, ".majC"}, 32'(majC), 32'(e.maj32));
        checkOutput({tag, ".tieC"}, 32'(tieC), 32'(e.tie32));
    endtask

    task automatic driveVec(input vecT v);
        inSeq    = v.seq;
        inMode   = v.mode;
        inThresh = v.thresh;
    endtask

    // Independent reference for random words, built on $countones and the vote rules.
    function automatic vecT modelOf(input logic [31:0] seq, input logic mode, input logic [5:0] thr);
        vecT r;
        int  o8;
        int  o32;
        o8  = $countones(seq[7:0]);
        o32 = $countones(seq);
        r.seq    = seq;
        r.mode   = mode;
        r.thresh = thr;
        r.ones8  = 4'(o8);
        r.ones32 = 6'(o32);
        r.tie8   = (2 * o8 == 8);
        r.tie32  = (2 * o32 == 32);
        if (mode) begin
            r.maj8Lo = (o8 >= int'(thr[3:0]));
            r.maj8Hi = r.maj8Lo;
            r.maj32  = (o32 >= int'(thr));
        end else begin
            r.maj8Lo = (2 * o8 > 8);
            r.maj8Hi = (2 * o8 >= 8);
            r.maj32  = (2 * o32 >= 32);
        end
        return r;
    endfunction

    // One isolated word: accepted at the first edge, result visible after the second.
    task automatic applyStimulus(input int idx);
        @(negedge clk);
        driveVec(vecs[idx]);
        inValid  = 1'b1;
        outReady = 1'b1;
        #1;
        checkOutput($sformatf("v%0d.inReady", idx), 32'(readyA), 32'd1);
        @(negedge clk);
        inValid  = 1'b0;
        inSeq    = ~inSeq;
        inMode   = ~inMode;
        inThresh = ~inThresh;
        #1;
        checkOutput($sformatf("v%0d.earlyValid", idx), 32'(validA), 32'd0);
        @(negedge clk);
        #1;
        checkRes($sformatf("v%0d", idx), vecs[idx]);
    endtask

    initial begin
        int  sent;
        int  got;
        int  cyc;
        bit  stalledPrev;
        logic       prevMaj;
        logic       prevTie;
        logic [3:0] prevOnes;
        vecT e;

        //              seq            mode  thr   o8    lo    hi    t8    o32    m32   t32
        vecs[0]  = '{32'h0000_00E1, 1'b0, 6'd0, 4'd4, 1'b0, 1'b1, 1'b1, 6'd4,  1'b0, 1'b0};
        vecs[1]  = '{32'h0001_FFFF, 1'b0, 6'd0, 4'd8, 1'b1, 1'b1, 1'b0, 6'd17, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_FFFF, 1'b0, 6'd0, 4'd8, 1'b1, 1'b1, 1'b0, 6'd16, 1'b1, 1'b1};
        vecs[3]  = '{32'h0000_0000, 1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0};
        vecs[4]  = '{32'h0000_0007, 1'b0, 6'd0, 4'd3, 1'b0, 1'b0, 1'b0, 6'd3,  1'b0, 1'b0};
        vecs[5]  = '{32'h0000_001F, 1'b0, 6'd0, 4'd5, 1'b1, 1'b1, 1'b0, 6'd5,  1'b0, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 1'b0, 6'd0, 4'd8, 1'b1, 1'b1, 1'b0, 6'd32, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_000F, 1'b1, 6'd4, 4'd4, 1'b1, 1'b1, 1'b1, 6'd4,  1'b1, 1'b0};
        vecs[8]  = '{32'h0000_000F, 1'b1, 6'd5, 4'd4, 1'b0, 1'b0, 1'b1, 6'd4,  1'b0, 1'b0};
        vecs[9]  = '{32'h0000_000F, 1'b1, 6'd0, 4'd4, 1'b1, 1'b1, 1'b1, 6'd4,  1'b1, 1'b0};
        vecs[10] = '{32'h0000_00FF, 1'b1, 6'd9, 4'd8, 1'b0, 1'b0, 1'b0, 6'd8,  1'b0, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 1'b1, 6'd8, 4'd8, 1'b1, 1'b1, 1'b0, 6'd32, 1'b1, 1'b0};

        // Reset state
        #2;
        checkOutput("rst.inReady", 32'(readyA), 32'd1);
        checkOutput("rst.validA", 32'(validA), 32'd0);
        checkOutput("rst.validC", 32'(validC), 32'd0);
        checkOutput("rst.onesC", 32'(onesC), 32'd0);
        checkOutput("rst.majB", 32'(majB), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(i);
        end

        // Back-to-back stream with the consumer stalled for cycles 3..7
        @(negedge clk);
        expQ.delete();
        sent = 0;
        got = 0;
        stalledPrev = 1'b0;
        prevMaj = 1'b0;
        prevTie = 1'b0;
        prevOnes = '0;
        for (cyc = 0; cyc < 200 && got < 10; cyc++) begin
            if (cyc > 0) @(negedge clk);
            outReady = !(cyc >= 3 && cyc <= 7);
            inValid  = (sent < 10);
            if (sent < 10) driveVec(vecs[sent]);
            #1;
            checkOutput("bp.inReady", 32'(readyA), 32'((expQ.size() < 2) || outReady));
            if (stalledPrev) begin
                checkOutput("bp.holdValid", 32'(validA), 32'd1);
                checkOutput("bp.holdMaj", 32'(majA), 32'(prevMaj));
                checkOutput("bp.holdOnes", 32'(onesA), 32'(prevOnes));
                checkOutput("bp.holdTie", 32'(tieA), 32'(prevTie));
            end
            if (validA && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("bp.extra", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkRes("bp", e);
                end
                got++;
            end
            stalledPrev = validA && !outReady;
            prevMaj  = majA;
            prevOnes = onesA;
            prevTie  = tieA;
            if (inValid && readyA) begin
                expQ.push_back(vecs[sent]);
                sent++;
            end
        end
        inValid = 1'b0;
        checkOutput("bp.count", 32'(got), 32'd10);

        // Asynchronous reset with two words in flight
        @(negedge clk);
        outReady = 1'b0;
        driveVec(vecs[1]);
        inValid = 1'b1;
        @(negedge clk);
        driveVec(vecs[6]);
        @(negedge clk);
        inValid = 1'b0;
        #1;
        checkOutput("ar.preValid", 32'(validA), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ar.validA", 32'(validA), 32'd0);
        checkOutput("ar.validC", 32'(validC), 32'd0);
        checkOutput("ar.onesA", 32'(onesA), 32'd0);
        checkOutput("ar.majA", 32'(majA), 32'd0);
        checkOutput("ar.onesC", 32'(onesC), 32'd0);
        checkOutput("ar.inReady", 32'(readyA), 32'd1);
        #1;
        rst = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("ar.noGhost", 32'(validA | validB | validC), 32'd0);
        end
        applyStimulus(0);

        // Random traffic against the reference model
        @(negedge clk);
        expQ.delete();
        sent = 0;
        got = 0;
        for (cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            @(negedge clk);
            inValid  = (sent < 10000) && ($urandom_range(3, 0) != 0);
            inSeq    = $urandom();
            inMode   = 1'($urandom_range(1, 0));
            inThresh = 6'($urandom_range(34, 0));
            outReady = ($urandom_range(3, 0) != 0);
            #1;
            checkOutput("rnd.inReady", 32'(readyA), 32'((expQ.size() < 2) || outReady));
            if (validA && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("rnd.extra", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkRes("rnd", e);
                end
                got++;
            end
            if (inValid && readyA) begin
                expQ.push_back(modelOf(inSeq, inMode, inThresh));
                sent++;
            end
        end
        inValid = 1'b0;
        checkOutput("rnd.count", 32'(got), 32'd10000);
        checkOutput("rnd.leftover", 32'(expQ.size()), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("rnd.idle", 32'(validA | validB | validC), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
